// File: rtl/aluctl_pkg.sv
// aluctl_pkg: opcode constants, ALU control codes and pipeline states shared by the aluctl blocks.
package aluctl_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] F7_BASE       = 7'b0000000;
    localparam logic [6:0] F7_ALT        = 7'b0100000;
    localparam logic [6:0] F7_MEXT       = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0011,
        ALU_SRL  = 4'b0100,
        ALU_AND  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_XOR  = 4'b1010,
        ALU_REM  = 4'b1011,
        ALU_MUL  = 4'b1100,
        ALU_MULH = 4'b1101,
        ALU_DIV  = 4'b1110,
        ALU_ILL  = 4'b1111
    } alu_ctl_e;

    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_WAIT} state_e;

    function automatic alu_ctl_e base_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_ctl_e mext_op(input logic [2:0] f3);
        return f3 == 3'b000 ? ALU_MUL : !f3[2] ? ALU_MULH : !f3[1] ? ALU_DIV : ALU_REM;
    endfunction

endpackage

// File: rtl/aluctl_dec.sv
// aluctl_dec: combinational instruction-field decode to ALU control.
// ALUCTL_MEXT_EN adds the multi-cycle M-extension ops; otherwise they decode as illegal.
module aluctl_dec #(
    parameter int XLEN = 32
) (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] code,
    output logic       word_op,
    output logic       illegal,
    output logic       multicycle
);
    import aluctl_pkg::*;

    logic rtype_ok;

    always_comb begin
        code       = ALU_ILL;
        word_op    = 1'b0;
        multicycle = 1'b0;
        rtype_ok   = funct7 == F7_BASE || funct7 == F7_ALT;
        // Immediate-form funct7 carries immediate bits, so only shifts look at bit 5.
        if (opcode[1:0] != 2'b11 ||
            opcode inside {OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR})
            code = ALU_ADD;
        else if (opcode == OPC_OP_IMM)
            code = base_op(funct3, funct3 == 3'b101 && funct7[5]);
        else if (opcode == OPC_OP && rtype_ok)
            code = base_op(funct3, funct7[5]);
        else if (XLEN == 64 && ((opcode == OPC_OP_32 && rtype_ok) || opcode == OPC_OP_IMM_32) &&
                 funct3 inside {3'b000, 3'b001, 3'b101}) begin
            code    = base_op(funct3, opcode == OPC_OP_32 ? funct7[5] : funct3 == 3'b101 && funct7[5]);
            word_op = 1'b1;
        end
`ifdef ALUCTL_MEXT_EN
        else if (funct7 == F7_MEXT && (opcode == OPC_OP || (XLEN == 64 && opcode == OPC_OP_32))) begin
            code       = mext_op(funct3);
            word_op    = opcode == OPC_OP_32;
            multicycle = 1'b1;
        end
`endif
        illegal = code == ALU_ILL;
    end

endmodule

// File: rtl/aluctl_pipe.sv
// aluctl_pipe: one-entry registered ALU-control decode stage with multi-cycle hold for MDU ops.
// ALUCTL_MEXT_EN enables M-extension decode and the WAIT state; otherwise mdu_busy stays 0.
module aluctl_pipe #(
    parameter int XLEN    = 32,
    parameter int MDU_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] alu_ctl,
    output logic       word_op,
    output logic       illegal,
    output logic       mdu_busy
);
    import aluctl_pkg::*;

    state_e     state, state_n;
    logic [3:0] cnt;
    logic [3:0] d_code;
    logic       d_word, d_ill, d_mc, accept;

    aluctl_dec #(.XLEN(XLEN)) u_dec (
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .code       (d_code),
        .word_op    (d_word),
        .illegal    (d_ill),
        .multicycle (d_mc)
    );

    assign out_valid = state == ST_FULL;
    assign mdu_busy  = state == ST_WAIT;

    always_comb begin
        in_ready = state == ST_EMPTY ? 1'b1 : state == ST_FULL ? out_ready : 1'b0;
        accept   = in_valid && in_ready;
        state_n  = state;
        if (accept)
            state_n = d_mc ? ST_WAIT : ST_FULL;
        else if (state == ST_FULL && out_ready)
            state_n = ST_EMPTY;
        else if (state == ST_WAIT && cnt == 4'd0)
            state_n = ST_FULL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_EMPTY;
            cnt     <= 4'd0;
            alu_ctl <= 4'd0;
            word_op <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                alu_ctl <= d_code;
                word_op <= d_word;
                illegal <= d_ill;
                cnt     <= d_mc ? 4'(MDU_LAT - 1) : 4'd0;
            end else if (state == ST_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_aluctl_pipe.sv
// tb_aluctl_pipe: scoreboard bench for aluctl_pipe at XLEN=32 plus an XLEN=64 twin for W-op decode.
module tb_aluctl_pipe;

    typedef struct packed {
        logic [3:0] code;
        logic       wo;
        logic       ill;
    } exp_t;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] code;
        logic       ill;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;

    logic       in_ready, out_valid, word_op, illegal, mdu_busy;
    logic [3:0] alu_ctl;
    logic       in_ready64, out_valid64, word_op64, illegal64, mdu_busy64;
    logic [3:0] alu_ctl64;

    exp_t sb[$];
    exp_t sb64[$];
    int   checks = 0;
    int   errors = 0;

    aluctl_pipe #(.XLEN(32), .MDU_LAT(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .out_valid(out_valid), .out_ready(out_ready), .alu_ctl(alu_ctl),
        .word_op(word_op), .illegal(illegal), .mdu_busy(mdu_busy)
    );

    aluctl_pipe #(.XLEN(64), .MDU_LAT(4)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .out_valid(out_valid64), .out_ready(out_ready), .alu_ctl(alu_ctl64),
        .word_op(word_op64), .illegal(illegal64), .mdu_busy(mdu_busy64)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        in_valid = 1'b1;
        opcode   = op;
        funct3   = f3;
        funct7   = f7;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(7'b0110011, 3'b000, 7'b0100000);
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, mdu_busy, illegal, word_op} !== 4'b0000 || alu_ctl !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b busy=%b ill=%b wo=%b ctl=%b, want all 0",
                     out_valid, mdu_busy, illegal, word_op, alu_ctl);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b v=%b, want rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_sub;
        exp_t e;
        out_ready = 1'b1;
        drive(7'b0110011, 3'b000, 7'b0100000);
        sb.push_back('{4'b0001, 1'b0, 1'b0});
        @(negedge clk);
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || alu_ctl !== e.code || illegal !== e.ill || word_op !== e.wo) begin
            errors++;
            $display("FAIL sub: got v=%b ctl=%b ill=%b wo=%b, want v=1 ctl=%b ill=%b wo=%b",
                     out_valid, alu_ctl, illegal, word_op, e.code, e.ill, e.wo);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sub_drain: got v=%b, want 0", out_valid);
        end
    endtask

    task automatic test_stall;
        exp_t e;
        out_ready = 1'b0;
        drive(7'b0110011, 3'b000, 7'b0000000);
        sb.push_back('{4'b0000, 1'b0, 1'b0});
        @(negedge clk);
        drive(7'b0110011, 3'b100, 7'b0000000);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_ctl !== 4'b0000) begin
                errors++;
                $display("FAIL stall[%0d]: got rdy=%b v=%b ctl=%b, want rdy=0 v=1 ctl=0000",
                         k, in_ready, out_valid, alu_ctl);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        e = sb.pop_front();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || alu_ctl !== e.code) begin
            errors++;
            $display("FAIL stall_release: got rdy=%b v=%b ctl=%b, want rdy=1 v=1 ctl=%b",
                     in_ready, out_valid, alu_ctl, e.code);
        end
        sb.push_back('{4'b1010, 1'b0, 1'b0});
        @(negedge clk);
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || alu_ctl !== e.code || illegal !== e.ill) begin
            errors++;
            $display("FAIL stall_second: got v=%b ctl=%b ill=%b, want v=1 ctl=%b ill=%b",
                     out_valid, alu_ctl, illegal, e.code, e.ill);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: got v=%b, want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        vec_t v[3];
        exp_t e;
        v[0] = '{7'b0110011, 3'b000, 7'b0000000, 4'b0000, 1'b0};
        v[1] = '{7'b0110011, 3'b100, 7'b0000000, 4'b1010, 1'b0};
        v[2] = '{7'b0110011, 3'b011, 7'b0000000, 4'b1000, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) begin
                @(negedge clk);
                e = sb.pop_front();
                checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b1 || alu_ctl !== e.code || illegal !== e.ill) begin
                    errors++;
                    $display("FAIL b2b[%0d]: got v=%b rdy=%b ctl=%b ill=%b, want v=1 rdy=1 ctl=%b ill=%b",
                             i - 1, out_valid, in_ready, alu_ctl, illegal, e.code, e.ill);
                end
            end
            if (i < 3) begin
                drive(v[i].op, v[i].f3, v[i].f7);
                sb.push_back('{v[i].code, 1'b0, v[i].ill});
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got v=%b, want 0", out_valid);
        end
    endtask

    task automatic test_decode;
        vec_t v[13];
        exp_t e;
        v[0]  = '{7'b0000011, 3'b010, 7'b0000000, 4'b0000, 1'b0};
        v[1]  = '{7'b0110111, 3'b101, 7'b0100000, 4'b0000, 1'b0};
        v[2]  = '{7'b0000000, 3'b111, 7'b1111111, 4'b0000, 1'b0};
        v[3]  = '{7'b0010011, 3'b101, 7'b0100000, 4'b1001, 1'b0};
        v[4]  = '{7'b0010011, 3'b010, 7'b0100000, 4'b0111, 1'b0};
        v[5]  = '{7'b0110011, 3'b001, 7'b0000000, 4'b0011, 1'b0};
        v[6]  = '{7'b0110011, 3'b101, 7'b0000000, 4'b0100, 1'b0};
        v[7]  = '{7'b0110011, 3'b101, 7'b0100000, 4'b1001, 1'b0};
        v[8]  = '{7'b0110011, 3'b110, 7'b0000000, 4'b0110, 1'b0};
        v[9]  = '{7'b0110011, 3'b111, 7'b0000000, 4'b0101, 1'b0};
        v[10] = '{7'b0110011, 3'b010, 7'b0000000, 4'b0111, 1'b0};
        v[11] = '{7'b1111111, 3'b000, 7'b0000000, 4'b1111, 1'b1};
        v[12] = '{7'b0010011, 3'b000, 7'b0100000, 4'b0000, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i <= 13; i++) begin
            if (i > 0) begin
                @(negedge clk);
                e = sb.pop_front();
                checks++;
                if (out_valid !== 1'b1 || alu_ctl !== e.code || illegal !== e.ill || word_op !== e.wo) begin
                    errors++;
                    $display("FAIL decode[%0d]: got v=%b ctl=%b ill=%b wo=%b, want v=1 ctl=%b ill=%b wo=%b",
                             i - 1, out_valid, alu_ctl, illegal, word_op, e.code, e.ill, e.wo);
                end
            end
            if (i < 13) begin
                drive(v[i].op, v[i].f3, v[i].f7);
                sb.push_back('{v[i].code, 1'b0, v[i].ill});
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_mdu;
        exp_t e;
        out_ready = 1'b1;
        drive(7'b0110011, 3'b100, 7'b0000001);
`ifdef ALUCTL_MEXT_EN
        sb.push_back('{4'b1110, 1'b0, 1'b0});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (mdu_busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL mdu_wait[%0d]: got busy=%b v=%b rdy=%b, want busy=1 v=0 rdy=0",
                         k, mdu_busy, out_valid, in_ready);
            end
        end
`else
        sb.push_back('{4'b1111, 1'b0, 1'b1});
`endif
        @(negedge clk);
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || mdu_busy !== 1'b0 || alu_ctl !== e.code || illegal !== e.ill) begin
            errors++;
            $display("FAIL mdu_result: got v=%b busy=%b ctl=%b ill=%b, want v=1 busy=0 ctl=%b ill=%b",
                     out_valid, mdu_busy, alu_ctl, illegal, e.code, e.ill);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || mdu_busy !== 1'b0) begin
            errors++;
            $display("FAIL mdu_drain: got v=%b busy=%b, want 0 0", out_valid, mdu_busy);
        end
    endtask

    task automatic test_word;
        vec_t v[2];
        exp_t w[2];
        exp_t e, e64;
        v[0] = '{7'b0111011, 3'b000, 7'b0000000, 4'b1111, 1'b1};
        v[1] = '{7'b0011011, 3'b101, 7'b0100000, 4'b1111, 1'b1};
        w[0] = '{4'b0000, 1'b1, 1'b0};
        w[1] = '{4'b1001, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(v[i].op, v[i].f3, v[i].f7);
            sb.push_back('{v[i].code, 1'b0, v[i].ill});
            sb64.push_back(w[i]);
            @(negedge clk);
            in_valid = 1'b0;
            e   = sb.pop_front();
            e64 = sb64.pop_front();
            checks++;
            if (out_valid !== 1'b1 || alu_ctl !== e.code || illegal !== e.ill || word_op !== e.wo) begin
                errors++;
                $display("FAIL word32[%0d]: got v=%b ctl=%b ill=%b wo=%b, want v=1 ctl=%b ill=%b wo=%b",
                         i, out_valid, alu_ctl, illegal, word_op, e.code, e.ill, e.wo);
            end
            checks++;
            if (out_valid64 !== 1'b1 || alu_ctl64 !== e64.code || illegal64 !== e64.ill || word_op64 !== e64.wo) begin
                errors++;
                $display("FAIL word64[%0d]: got v=%b ctl=%b ill=%b wo=%b, want v=1 ctl=%b ill=%b wo=%b",
                         i, out_valid64, alu_ctl64, illegal64, word_op64, e64.code, e64.ill, e64.wo);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_abort;
        exp_t e;
        logic seen;
        out_ready = 1'b0;
        drive(7'b0110011, 3'b100, 7'b0000001);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
`ifdef ALUCTL_MEXT_EN
        if (mdu_busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pending: got busy=%b, want 1", mdu_busy);
        end
`else
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_pending: got v=%b, want 1", out_valid);
        end
`endif
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, mdu_busy, illegal, word_op} !== 4'b0000 || alu_ctl !== 4'd0) begin
            errors++;
            $display("FAIL abort_reset: got v=%b busy=%b ill=%b wo=%b ctl=%b, want all 0",
                     out_valid, mdu_busy, illegal, word_op, alu_ctl);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | out_valid | mdu_busy;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_ghost: got stale activity=%b after release, want 0", seen);
        end
        drive(7'b0110011, 3'b000, 7'b0100000);
        sb.push_back('{4'b0001, 1'b0, 1'b0});
        @(negedge clk);
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || alu_ctl !== e.code || illegal !== e.ill) begin
            errors++;
            $display("FAIL abort_next: got v=%b ctl=%b ill=%b, want v=1 ctl=%b ill=%b",
                     out_valid, alu_ctl, illegal, e.code, e.ill);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_sub();
        test_stall();
        test_back_to_back();
        test_decode();
        test_mdu();
        test_word();
        test_reset_abort();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d pending, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
